// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Power-up and lock-supervision controller for the iCE40 PLL wrapper. Runs on
// the 12 MHz reference clock.
//
// Sequence:
//   - Hold the PLL in reset.
//   - Wait for LOCK.
//   - Require LOCK to stay stable for a programmable window.
//   - Release the system reset.
//
// A PLL that never locks is retried; after repeated timeouts the controller
// parks in FAULT until relock_req or reset_n.
//
// Ports:
//   clock_in    - 12 MHz reference clock (same pin that feeds the PLL)
//   reset_n     - asynchronous active-low reset
//   locked      - PLL LOCK output, asynchronous to clock_in
//   relock_req  - single-cycle request to restart the full sequence
//   pll_resetb  - PLL RESETB pin drive, 0 holds the PLL in reset
//   sys_rst_n   - active-low reset for downstream logic (high only in RUN)
//   pll_ready   - high only in RUN
//   fault       - high only in FAULT
//   retry_count - lock timeouts since the last RUN entry or restart
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int PLL_RESET_CYCLES    = 12,
    parameter int LOCK_TIMEOUT_CYCLES = 12000,
    parameter int LOCK_STABLE_CYCLES  = 1200,
    parameter int MAX_RETRIES         = 2,
    parameter int CNT_W               = 16
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       relock_req,
    output logic       pll_resetb,
    output logic       sys_rst_n,
    output logic       pll_ready,
    output logic       fault,
    output logic [1:0] retry_count
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // Terminal counts: a phase of N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    state_t           state_r;
    state_t           state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       retry_nx_s;
    logic             cnt_clr_s;
    logic             sync1_r;
    logic             lock_sync_r;

    // Two-flop synchronizer bringing the asynchronous LOCK into clock_in.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r     <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            sync1_r     <= locked;
            lock_sync_r <= sync1_r;
        end
    end

    // Next-state and next-retry decision; relock_req overrides everything.
    always_comb begin
        state_nx_s = state_r;
        retry_nx_s = retry_count;
        if (relock_req) begin
            state_nx_s = ST_PLL_RST;
            retry_nx_s = 2'd0;
        end else begin
            case (state_r)
                ST_PLL_RST: begin
                    if (cnt_r == RST_LAST) begin
                        state_nx_s = ST_WAIT_LOCK;
                    end else begin
                        state_nx_s = ST_PLL_RST;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_sync_r) begin
                        state_nx_s = ST_STABLE;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        if (retry_count == RETRY_MAX) begin
                            state_nx_s = ST_FAULT;
                        end else begin
                            state_nx_s = ST_PLL_RST;
                            retry_nx_s = retry_count + 2'd1;
                        end
                    end else begin
                        state_nx_s = ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    // A lock drop wins even on the last cycle of the window.
                    if (!lock_sync_r) begin
                        state_nx_s = ST_WAIT_LOCK;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_nx_s = ST_RUN;
                        retry_nx_s = 2'd0;
                    end else begin
                        state_nx_s = ST_STABLE;
                    end
                end
                ST_RUN: begin
                    if (!lock_sync_r) begin
                        state_nx_s = ST_PLL_RST;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_nx_s = ST_FAULT;
                end
                default: begin
                    state_nx_s = ST_PLL_RST;
                    retry_nx_s = 2'd0;
                end
            endcase
        end
        // relock_req in PLL_RST keeps the state but must still restart the count.
        cnt_clr_s = relock_req || (state_nx_s != state_r);
    end

    // FSM state, phase counter, retry count and outputs decoded from next state.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_PLL_RST;
            cnt_r       <= '0;
            retry_count <= 2'd0;
            pll_resetb  <= 1'b0;
            sys_rst_n   <= 1'b0;
            pll_ready   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            retry_count <= retry_nx_s;
            if (cnt_clr_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            case (state_nx_s)
                ST_WAIT_LOCK, ST_STABLE: begin
                    pll_resetb <= 1'b1;
                    sys_rst_n  <= 1'b0;
                    pll_ready  <= 1'b0;
                    fault      <= 1'b0;
                end
                ST_RUN: begin
                    pll_resetb <= 1'b1;
                    sys_rst_n  <= 1'b1;
                    pll_ready  <= 1'b1;
                    fault      <= 1'b0;
                end
                ST_FAULT: begin
                    pll_resetb <= 1'b0;
                    sys_rst_n  <= 1'b0;
                    pll_ready  <= 1'b0;
                    fault      <= 1'b1;
                end
                default: begin
                    pll_resetb <= 1'b0;
                    sys_rst_n  <= 1'b0;
                    pll_ready  <= 1'b0;
                    fault      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer (P=4, T=20, S=8, MAX_RETRIES=2).
// Output vector layout: {pll_resetb, sys_rst_n, pll_ready, fault, retry_count}.
module tb_pll_lock_sequencer;

    localparam int P  = 4;
    localparam int T  = 20;
    localparam int S  = 8;
    localparam int MR = 2;

    logic       clk;
    logic       reset_n;
    logic       locked;
    logic       relock_req;
    logic       pll_resetb;
    logic       sys_rst_n;
    logic       pll_ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [5:0] outs;

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_sequencer #(
        .PLL_RESET_CYCLES   (P),
        .LOCK_TIMEOUT_CYCLES(T),
        .LOCK_STABLE_CYCLES (S),
        .MAX_RETRIES        (MR),
        .CNT_W              (16)
    ) dut (
        .clock_in   (clk),
        .reset_n    (reset_n),
        .locked     (locked),
        .relock_req (relock_req),
        .pll_resetb (pll_resetb),
        .sys_rst_n  (sys_rst_n),
        .pll_ready  (pll_ready),
        .fault      (fault),
        .retry_count(retry_count)
    );

    assign outs = {pll_resetb, sys_rst_n, pll_ready, fault, retry_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance n active edges, ending on the following falling edge.
    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        relock_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Phases are tracked by the absolute edge at which they were entered:
    // a phase of length N entered at edge e ends at edge e+N.
    localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FLT = 4;
    int m_ph, m_ent, m_ret, m_edge;
    bit m_samp[$];

    task automatic model_reset();
        m_ph = M_RST; m_ent = 0; m_ret = 0; m_edge = 0;
        m_samp.delete();
    endtask

    task automatic model_edge(input bit lk, input bit rq);
        bit ls;
        m_edge++;
        // The FSM sees the LOCK value sampled two edges earlier.
        ls = (m_samp.size() >= 2) ? m_samp[m_samp.size() - 2] : 1'b0;
        m_samp.push_back(lk);
        if (m_samp.size() > 4) void'(m_samp.pop_front());
        if (rq) begin
            m_ph = M_RST; m_ent = m_edge; m_ret = 0;
        end else if (m_ph == M_RST) begin
            if (m_edge == m_ent + P) begin m_ph = M_WAIT; m_ent = m_edge; end
        end else if (m_ph == M_WAIT) begin
            if (ls) begin
                m_ph = M_STAB; m_ent = m_edge;
            end else if (m_edge == m_ent + T) begin
                if (m_ret == MR) m_ph = M_FLT;
                else begin m_ret++; m_ph = M_RST; end
                m_ent = m_edge;
            end
        end else if (m_ph == M_STAB) begin
            if (!ls) begin
                m_ph = M_WAIT; m_ent = m_edge;
            end else if (m_edge == m_ent + S) begin
                m_ph = M_RUN; m_ent = m_edge; m_ret = 0;
            end
        end else if (m_ph == M_RUN) begin
            if (!ls) begin m_ph = M_RST; m_ent = m_edge; end
        end
    endtask

    function automatic logic [5:0] model_out();
        logic [5:0] o;
        o[5]   = (m_ph == M_WAIT) || (m_ph == M_STAB) || (m_ph == M_RUN);
        o[4]   = (m_ph == M_RUN);
        o[3]   = (m_ph == M_RUN);
        o[2]   = (m_ph == M_FLT);
        o[1:0] = 2'(m_ret);
        return o;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit         rst;
        logic       lk;
        logic       rq;
        int         n;
        logic [5:0] exp;
        string      nm;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    initial begin
        reset_n    = 1'b0;
        locked     = 1'b0;
        relock_req = 1'b0;

        // Clean start, lock loss in RUN, three failed attempts, relock recovery.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 0,  6'b000000, "reset_state"};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 3,  6'b000000, "edge3_resetb_low"};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1,  6'b100000, "edge4_resetb_rise"};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8,  6'b100000, "edge12_not_released"};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1,  6'b111000, "edge13_release"};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 5,  6'b111000, "run_hold"};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 2,  6'b111000, "loss_2_edges"};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1,  6'b000000, "loss_3_edges"};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 3,  6'b000000, "att1_rst"};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1,  6'b100000, "att1_wait"};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 19, 6'b100000, "att1_timeout_pre"};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1,  6'b000001, "retry1"};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4,  6'b100001, "att2_wait"};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 20, 6'b000010, "retry2"};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 23, 6'b100010, "fault_pre"};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1,  6'b000110, "fault_set"};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 10, 6'b000110, "fault_hold"};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1,  6'b000000, "relock_clear"};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 12, 6'b100000, "relock_edge12"};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1,  6'b111000, "relock_edge13"};
        // Stuck-low lock straight from reset: FAULT at edge 72.
        vecs[20] = '{1'b1, 1'b0, 1'b0, 71, 6'b100010, "stuck_edge71"};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1,  6'b000110, "stuck_edge72_fault"};

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) begin
                locked = vecs[i].lk;
                do_reset();
            end
            locked     = vecs[i].lk;
            relock_req = vecs[i].rq;
            if (vecs[i].n > 0) begin
                @(posedge clk);
                @(negedge clk);
                relock_req = 1'b0;
                step(vecs[i].n - 1);
            end
            check(vecs[i].nm, outs, vecs[i].exp);
        end

        // Glitch mid-window: lock low for edges 8..10, full window restarts.
        locked = 1'b1;
        do_reset();
        for (int n = 1; n <= 25; n++) begin
            locked = (n >= 8 && n <= 10) ? 1'b0 : 1'b1;
            step(1);
            check("glitch_seq", outs,
                  {(n >= 4) ? 1'b1 : 1'b0, (n >= 21) ? 2'b11 : 2'b00, 3'b000});
        end

        // Lock loss in RUN followed by immediate restore: P+S+1 re-release.
        locked = 1'b0;
        step(3);
        check("loss_run_drop", outs, 6'b000000);
        locked = 1'b1;
        step(P - 1);
        check("rerelease_rst", outs, 6'b000000);
        step(1);
        check("rerelease_wait", outs, 6'b100000);
        step(S);
        check("rerelease_pre", outs, 6'b100000);
        step(1);
        check("rerelease_run", outs, 6'b111000);

        // Asynchronous reset mid-STABLE, then a clean restart.
        locked = 1'b1;
        do_reset();
        step(8);
        check("mid_stable", outs, 6'b100000);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", outs, 6'b000000);
        @(negedge clk);
        reset_n = 1'b1;
        step(3);
        check("restart_edge3", outs, 6'b000000);
        step(1);
        check("restart_edge4", outs, 6'b100000);
        step(9);
        check("restart_edge13", outs, 6'b111000);

        // Randomized stimulus against the reference model.
        locked = 1'b1;
        do_reset();
        model_reset();
        for (int i = 0; i < 4000; i++) begin
            bit lk;
            bit rq;
            if ($urandom_range(0, 999) < 2) begin
                #2;
                reset_n = 1'b0;
                #1;
                check("rand_async_reset", outs, 6'b000000);
                model_reset();
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                lk = locked;
                if (lk) begin
                    if ($urandom_range(0, 59) == 0) lk = 1'b0;
                end else begin
                    if ($urandom_range(0, 14) == 0) lk = 1'b1;
                end
                rq = ($urandom_range(0, 299) == 0);
                locked     = lk;
                relock_req = rq;
                @(posedge clk);
                model_edge(lk, rq);
                @(negedge clk);
                relock_req = 1'b0;
                check("random", outs, model_out());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Power-up and lock-supervision controller for the iCE40 PLL wrapper (12 MHz reference in, 60 MHz system clock out). It runs on the 12 MHz reference clock. It drives the PLL's RESETB, watches the asynchronous LOCK output and releases the system reset only after lock has been stable for a programmable window. On lock loss it re-asserts the system reset. It retries a PLL that does not lock and latches a fault after repeated failures.

## Interface
Parameters:
- PLL_RESET_CYCLES, 12: cycles RESETB is held low per attempt (1 µs at 12 MHz).
- LOCK_TIMEOUT_CYCLES, 12000: maximum cycles to wait for lock per attempt (1 ms).
- LOCK_STABLE_CYCLES, 1200: consecutive synchronized-lock cycles required before release (100 µs).
- MAX_RETRIES, 2: timeouts tolerated before FAULT; 0–3.
- CNT_W, 16: cycle counter width.
- Legal values: each *_CYCLES parameter is ≥1 and <2^CNT_W.

Ports:
- clock_in, in, 1: 12 MHz reference clock (the same pin that feeds the PLL).
- reset_n, in, 1: asynchronous, active-low reset.
- locked, in, 1: PLL LOCK output.
  - It is asynchronous to clock_in.
  - It passes through a 2-flop synchronizer (reset to 0) to produce lock_s.
- relock_req, in, 1: single-cycle request to restart the full sequence.
- pll_resetb, out, 1: drives the PLL RESETB pin; 0 holds the PLL in reset.
- sys_rst_n, out, 1: active-low reset for downstream logic.
  - The consumer synchronizes its deassertion into the clock_out domain.
- pll_ready, out, 1: high only in RUN.
- fault, out, 1: high only in FAULT.
- retry_count, out, 2: timeouts since the last RUN entry or restart.

## Operation
- All outputs are registered. Their reset values are:
  - pll_resetb=0, sys_rst_n=0, pll_ready=0, fault=0, retry_count=0.
  - State is PLL_RST, counter is 0, synchronizer flops are 0.
- Single counter cnt: cleared on every state transition, otherwise incremented each cycle.
- PLL_RST: pll_resetb=0, sys_rst_n=0.
  - At cnt==PLL_RESET_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK: pll_resetb=1, sys_rst_n=0.
  - If lock_s=1, go to STABLE.
  - Else, at cnt==LOCK_TIMEOUT_CYCLES-1:
    - If retry_count==MAX_RETRIES, go to FAULT.
    - Otherwise increment retry_count and go to PLL_RST.
- STABLE: pll_resetb=1, sys_rst_n=0.
  - If lock_s=0, go to WAIT_LOCK. The timeout restarts from 0 and the stability window restarts in full.
  - Else, at cnt==LOCK_STABLE_CYCLES-1, go to RUN.
- RUN: pll_resetb=1, sys_rst_n=1, pll_ready=1. retry_count is cleared on entry.
  - If lock_s=0, go to PLL_RST: sys_rst_n and pll_resetb both drop on the same edge.
  - retry_count is not incremented by this transition.
- FAULT: pll_resetb=0, sys_rst_n=0, fault=1.
  - Terminal state. Only reset_n or relock_req leaves it.
- relock_req=1 has the highest priority in every state. On the next edge:
  - state→PLL_RST, cnt=0, retry_count=0.
  - Outputs take their PLL_RST values: pll_resetb=0, sys_rst_n=0, pll_ready=0, fault=0.
- Outputs are decoded from the next state and registered, so every output changes on the same edge as its state transition.
- sys_rst_n==1 if and only if state==RUN, and pll_ready==sys_rst_n at all times.
- reset_n asserted mid-sequence returns every output to its reset value immediately (asynchronously).

## Timing
- Synchronizer latency: lock_s follows locked 2 clock_in edges later.
- Nominal release:
  - Condition: locked high from reset release (counting from the first edge after release).
  - WAIT_LOCK is entered at edge P, STABLE at edge P+1 and RUN at edge P+S+1.
  - Here P=PLL_RESET_CYCLES and S=LOCK_STABLE_CYCLES. Defaults give 1213 edges.
- Late lock: WAIT_LOCK→STABLE occurs on the first edge at which lock_s is sampled high.
- Failed attempt: one costs P+T edges, where T=LOCK_TIMEOUT_CYCLES.
- Time to FAULT: with locked stuck low, FAULT is entered at edge (MAX_RETRIES+1)·(P+T).
- Lock loss in RUN: sys_rst_n falls 3 edges after locked falls (2 synchronizer edges plus 1 register edge).
- Lock loss at the final STABLE cycle: lock_s=0 at cnt==S-1 takes priority, and the next state is WAIT_LOCK, not RUN.

## Test plan
Parameters for all tests: P=4, T=20, S=8, MAX_RETRIES=2.
- Clean start: locked=1 from reset.
  - Required: pll_resetb rises at edge 4, sys_rst_n and pll_ready rise at edge 13, retry_count=0.
- Stuck-low lock: locked=0 throughout.
  - Required: three 4-cycle pll_resetb low windows, retry_count steps 1→2.
  - Required: fault=1 at edge 72, with pll_resetb=0 and sys_rst_n=0 held afterwards.
- Glitch during STABLE: locked drops for 3 cycles in the middle of the stability window.
  - Required: return to WAIT_LOCK, then a full 8-cycle window before sys_rst_n rises; no output glitch.
- Lock loss in RUN: locked falls.
  - Required: sys_rst_n=0 and pll_resetb=0 exactly 3 edges later.
  - Required: with locked restored, a full P+S+1 sequence re-releases.
- Recovery from FAULT: pulse relock_req in FAULT.
  - Required: fault=0 and retry_count=0 next edge.
  - Required: with locked=1, sys_rst_n rises 13 edges later.
- Asynchronous reset mid-STABLE: assert reset_n mid-STABLE.
  - Required: all outputs at their reset values with no clock edge; the sequence restarts from PLL_RST after release.
